instr_fetch_mem: RTL and testbench
==================================

Name: instr_fetch_mem

Overview:
- Parametrised, clocked successor to the combinational byte-addressed instruction memory.
- Holds DEPTH bytes and returns big-endian instructions of IW bits through a valid/ready fetch handshake with 1-cycle latency.
- Reports misaligned and out-of-range fetches.
- A byte-wide load port, gated by a mode FSM, lets the program loader write the image at run time.
- Sits between the PC/fetch stage and the decoder.

Parameters:
- ADDR_W, 32, fetch/load address width.
- DEPTH, 256, memory size in bytes; power of 2, at least IW/8.
- IW, 32, instruction width; multiple of 8, at most 64.
- ALIGN_CHECK, 1, 1 = flag fetches whose address is not a multiple of IW/8; 0 = never flag.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_valid  in  1  fetch request present.
- fetch_addr  in  ADDR_W  byte address of the instruction's first (most significant) byte.
- fetch_ready  out  1  request accepted this cycle when high together with fetch_valid.
- rsp_valid  out  1  response held in the output register.
- rsp_ready  in  1  consumer takes the response.
- rsp_instr  out  IW  {mem[a], mem[a+1], ..., mem[a+IW/8-1]}, big-endian.
- rsp_err_align  out  1  misaligned fetch.
- rsp_err_range  out  1  fetch_addr >= DEPTH.
- load_en  in  1  request LOAD mode.
- load_we  in  1  byte write strobe; effective only in LOAD.
- load_addr  in  ADDR_W  byte write address.
- load_data  in  8  byte to write.
- load_err  out  1  one-cycle pulse: write dropped, load_addr >= DEPTH.
- load_cnt  out  ADDR_W  bytes written since the last entry to LOAD.
- busy  out  1  high whenever the FSM is not in RUN.

Behaviour:
- Reset (async assert, sync release):
  - State RUN; rsp_valid, rsp_err_align, rsp_err_range, load_err = 0; rsp_instr = 0; load_cnt = 0; busy = 0.
  - Memory array is not cleared by reset.
- FSM states: RUN, DRAIN, LOAD.
  - RUN -> LOAD when load_en=1 and (rsp_valid=0, or rsp_valid=1 and rsp_ready=1 this cycle).
  - RUN -> DRAIN when load_en=1 and a response is held and not taken this cycle.
  - DRAIN -> LOAD once the response is taken; DRAIN -> RUN if load_en drops first.
  - LOAD -> RUN the cycle after load_en=0.
- fetch_ready = (state==RUN) && !load_en && (!rsp_valid || rsp_ready). Combinational; no dependency on fetch_valid.
- Fetch accept:
  - Output register loads on the next edge; rsp_valid=1 one cycle after acceptance.
  - Back-to-back accepts give a throughput of 1 per cycle while rsp_ready=1.
- Response hold: while rsp_valid=1 and rsp_ready=0, rsp_instr and both error bits hold stable.
- rsp_valid clears after a take with no new accept in the same cycle.
- Byte indexes: (fetch_addr+k) mod DEPTH for k in 0..IW/8-1. A fetch at the top of memory wraps to byte 0.
- Range error: rsp_err_range = (fetch_addr >= DEPTH) over the full ADDR_W compare; in that case rsp_instr = 0.
- Alignment error: rsp_err_align = ALIGN_CHECK && (fetch_addr mod (IW/8) != 0). Data is still returned normally.
- Both error bits may be set together.
- Load writes (state==LOAD && load_we):
  - load_addr < DEPTH: mem[load_addr] <= load_data; load_cnt increments, saturating at all-ones.
  - Otherwise: no write; load_err pulses high for exactly one cycle.
  - load_we is ignored in RUN and DRAIN.
- load_cnt clears on each RUN/DRAIN -> LOAD transition and holds its value in RUN.
- A fetch never observes a partial load; fetches are blocked throughout LOAD.
- Reset mid-operation: a pending response is discarded and the FSM returns to RUN. Bytes already written are retained.

Decomposition:
- Shared package (cpu_pkg): fsm state enum {RUN, DRAIN, LOAD}; localparams IB = IW/8 and OFS_W = clog2(IB); the default ADDR_W/IW constants shared with the fetch stage.
- One sub-module, byte_mem_rd: the DEPTH x 8 array with one byte write port and IB combinational read taps with mod-DEPTH indexing.
- FSM, handshake and output register stay in the top.

Test Plan:
- Defaults; in LOAD write bytes 00 FF 55 0F CC 33 F0 92 at 0..7; fetch 0 and 4 back-to-back with rsp_ready=1.
  - Required: 0x00FF550F then 0xCC33F092 on consecutive cycles, 1-cycle latency, load_cnt=8.
- Fetch 4 with rsp_ready=0 for 3 cycles.
  - Required: rsp_valid=1, rsp_instr=0xCC33F092 stable, fetch_ready=0; the take then reopens fetch_ready.
- Fetch 2.
  - Required: rsp_instr=0x550FCC33, rsp_err_align=1, rsp_err_range=0.
- Fetch 254 (DEPTH=256) after writing 0xAA at 254, 0xBB at 255, 0x11 at 0, 0x22 at 1.
  - Required: rsp_instr=0xAABB1122 (wrap) with rsp_err_align=1.
- Fetch 0x100.
  - Required: rsp_err_range=1, rsp_instr=0. In LOAD, write to 0x100: load_err one-cycle pulse, load_cnt unchanged.
- Raise load_en while a response is held.
  - Required: state DRAIN, busy=1, load_we ignored. After rsp_ready: LOAD. Assert rst_n=0 mid-LOAD: rsp_valid=0, state RUN immediately, earlier writes readable after release.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the fetch stage and the instruction memory.
//   - fsm_state_e : mode FSM of instr_fetch_mem (RUN / DRAIN / LOAD)
//   - ADDR_W_DEF, IW_DEF : default address and instruction widths
//   - IB, OFS_W : bytes per default-width instruction and the byte-offset width
//   - ofs_bits() : byte-offset width for any instruction byte count (min 1)
package cpu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int IW_DEF     = 32;

  // Width of the in-instruction byte offset; never zero so it can size a slice.
  function automatic int ofs_bits(input int ib);
    return (ib > 1) ? $clog2(ib) : 1;
  endfunction

  localparam int IB    = IW_DEF / 8;
  localparam int OFS_W = ofs_bits(IB);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_LOAD  = 2'd2
  } fsm_state_e;

endpackage

// File: rtl/byte_mem_rd.sv
// byte_mem_rd: DEPTH x 8 byte array with one synchronous byte write port and
// NB combinational read taps. Tap k reads byte (raddr + k) mod DEPTH and lands
// in the big-endian position, so tap 0 is the most significant byte of rdata.
// Ports:
//   clk    in           write clock
//   we     in           byte write enable
//   waddr  in  AW       byte write address
//   wdata  in  8        byte to write
//   raddr  in  AW       read base address
//   rdata  out NB*8     {mem[raddr], ..., mem[raddr+NB-1]}
// The array is deliberately not reset: its contents survive a core reset.
module byte_mem_rd
  import cpu_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int NB    = IB,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [7:0]      wdata,
  input  logic [AW-1:0]   raddr,
  output logic [NB*8-1:0] rdata
);

  logic [7:0] mem_r [DEPTH];

  // Byte write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Read taps: AW-bit addition wraps naturally because DEPTH is a power of two.
  for (genvar k = 0; k < NB; k++) begin : g_tap
    logic [AW-1:0] idx_s;
    assign idx_s                       = raddr + AW'(k);
    assign rdata[(NB-1-k)*8 +: 8]      = mem_r[idx_s];
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: clocked, byte-addressed instruction memory between the PC
// stage and the decoder. Fetches use a valid/ready handshake with one cycle of
// latency into an output register; a mode FSM (RUN/DRAIN/LOAD) lets the loader
// write bytes at run time while fetches are blocked.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   fetch_valid/fetch_addr/fetch_ready   fetch request channel
//   rsp_valid/rsp_ready/rsp_instr        response channel (big-endian data)
//   rsp_err_align, rsp_err_range         misaligned / out-of-range fetch
//   load_en, load_we, load_addr, load_data   loader request and byte write
//   load_err                          one-cycle pulse for a dropped write
//   load_cnt                          bytes written since entering LOAD
//   busy                              FSM not in RUN
module instr_fetch_mem
  import cpu_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DEPTH       = 256,
  parameter int IW          = IW_DEF,
  parameter int ALIGN_CHECK = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_valid,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IW-1:0]     rsp_instr,
  output logic              rsp_err_align,
  output logic              rsp_err_range,
  input  logic              load_en,
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              load_err,
  output logic [ADDR_W-1:0] load_cnt,
  output logic              busy
);

  localparam int IBL  = IW / 8;
  localparam int OW   = (IW == IW_DEF) ? OFS_W : ofs_bits(IBL);
  localparam int MA_W = $clog2(DEPTH);

  fsm_state_e        state_r, state_nx_s;
  logic              rsp_valid_r, err_align_r, err_range_r, load_err_r, busy_r;
  logic [IW-1:0]     rsp_instr_r;
  logic [ADDR_W-1:0] load_cnt_r;
  logic [IW-1:0]     rd_data_s;
  logic              fetch_ready_s, accept_s, take_s;
  logic              range_s, align_s, ld_in_range_s, ld_wr_s, ld_drop_s, enter_load_s;

  assign fetch_ready_s = (state_r == ST_RUN) && !load_en && (!rsp_valid_r || rsp_ready);
  assign accept_s      = fetch_valid && fetch_ready_s;
  assign take_s        = rsp_valid_r && rsp_ready;

  // Range uses the full address; the memory taps only see the low MA_W bits.
  assign range_s       = fetch_addr >= ADDR_W'(DEPTH);
  assign align_s       = (ALIGN_CHECK != 0) && (IBL > 1) && (fetch_addr[OW-1:0] != {OW{1'b0}});

  assign ld_in_range_s = load_addr < ADDR_W'(DEPTH);
  assign ld_wr_s       = (state_r == ST_LOAD) && load_we && ld_in_range_s;
  assign ld_drop_s     = (state_r == ST_LOAD) && load_we && !ld_in_range_s;
  assign enter_load_s  = (state_r != ST_LOAD) && (state_nx_s == ST_LOAD);

  byte_mem_rd #(
    .DEPTH (DEPTH),
    .NB    (IBL),
    .AW    (MA_W)
  ) u_mem (
    .clk   (clk),
    .we    (ld_wr_s),
    .waddr (load_addr[MA_W-1:0]),
    .wdata (load_data),
    .raddr (fetch_addr[MA_W-1:0]),
    .rdata (rd_data_s)
  );

  // Mode FSM next state. DRAIN waits for the held response to leave before
  // LOAD so that no response can carry data from a half-written image.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (load_en) begin
          if (!rsp_valid_r || rsp_ready) begin
            state_nx_s = ST_LOAD;
          end else begin
            state_nx_s = ST_DRAIN;
          end
        end else begin
          state_nx_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!load_en) begin
          state_nx_s = ST_RUN;
        end else if (rsp_ready) begin
          state_nx_s = ST_LOAD;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_LOAD: begin
        if (!load_en) begin
          state_nx_s = ST_RUN;
        end else begin
          state_nx_s = ST_LOAD;
        end
      end
      default: state_nx_s = ST_RUN;
    endcase
  end

  // Mode state register and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      busy_r  <= (state_nx_s != ST_RUN);
    end
  end

  // Response output register: loads on accept, holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_instr_r <= {IW{1'b0}};
      err_align_r <= 1'b0;
      err_range_r <= 1'b0;
    end else if (accept_s) begin
      rsp_valid_r <= 1'b1;
      rsp_instr_r <= range_s ? {IW{1'b0}} : rd_data_s;
      err_align_r <= align_s;
      err_range_r <= range_s;
    end else if (take_s) begin
      rsp_valid_r <= 1'b0;
    end
  end

  // Loader status: dropped-write pulse and saturating byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_err_r <= 1'b0;
      load_cnt_r <= {ADDR_W{1'b0}};
    end else begin
      load_err_r <= ld_drop_s;
      if (enter_load_s) begin
        load_cnt_r <= {ADDR_W{1'b0}};
      end else if (ld_wr_s && !(&load_cnt_r)) begin
        load_cnt_r <= load_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign fetch_ready   = fetch_ready_s;
  assign rsp_valid     = rsp_valid_r;
  assign rsp_instr     = rsp_instr_r;
  assign rsp_err_align = err_align_r;
  assign rsp_err_range = err_range_r;
  assign load_err      = load_err_r;
  assign load_cnt      = load_cnt_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb_instr_fetch_mem: directed scenarios followed by randomized traffic, all
// checked against a behavioural model (byte array + pending-response record +
// mode variable) stepped once per clock. Inputs change #1 after the rising
// edge; fetch_ready is checked on the falling edge, registered outputs #1
// after the rising edge.
module tb_instr_fetch_mem;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_valid = 1'b0;
  logic [31:0] fetch_addr = 32'd0;
  logic        rsp_ready = 1'b0;
  logic        load_en = 1'b0;
  logic        load_we = 1'b0;
  logic [31:0] load_addr = 32'd0;
  logic [7:0]  load_data = 8'd0;
  logic        fetch_ready, rsp_valid, rsp_err_align, rsp_err_range, load_err, busy;
  logic [31:0] rsp_instr, load_cnt;

  instr_fetch_mem dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_valid(fetch_valid), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr),
    .rsp_err_align(rsp_err_align), .rsp_err_range(rsp_err_range),
    .load_en(load_en), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .load_err(load_err), .load_cnt(load_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: 0 = RUN, 1 = DRAIN, 2 = LOAD.
  logic [7:0]  mem_m [256];
  int          m_mode;
  bit          m_rv, m_ea, m_er, m_lerr;
  logic [31:0] m_instr, m_cnt;
  int          n_chk = 0;
  int          n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_mode = 0; m_rv = 0; m_ea = 0; m_er = 0; m_lerr = 0;
    m_instr = 32'd0; m_cnt = 32'd0;
  endtask

  function automatic logic [31:0] model_fetch(input logic [31:0] a);
    logic [31:0] v = 32'd0;
    for (int k = 0; k < 4; k++) v = {v[23:0], mem_m[(a + 32'(k)) % 32'd256]};
    return v;
  endfunction

  task automatic cycle();
    bit fr, acc, take;
    int nmode;
    @(negedge clk);
    fr = (m_mode == 0) && !load_en && (!m_rv || rsp_ready);
    check_val("fetch_ready", {63'd0, fetch_ready}, {63'd0, fr});
    acc  = fetch_valid && fr;
    take = m_rv && rsp_ready;
    if (acc) begin
      m_rv = 1;
      m_er = (fetch_addr >= 32'd256);
      m_ea = (fetch_addr % 32'd4) != 32'd0;
      m_instr = m_er ? 32'd0 : model_fetch(fetch_addr);
    end else if (take) begin
      m_rv = 0;
    end
    m_lerr = 0;
    if (m_mode == 2 && load_we) begin
      if (load_addr < 32'd256) begin
        mem_m[load_addr[7:0]] = load_data;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
        m_lerr = 1;
      end
    end
    case (m_mode)
      0:       nmode = !load_en ? 0 : ((!m_rv_before(take, acc) ) ? 2 : 1);
      1:       nmode = !load_en ? 0 : (rsp_ready ? 2 : 1);
      default: nmode = load_en ? 2 : 0;
    endcase
    if (nmode == 2 && m_mode != 2) m_cnt = 32'd0;
    m_mode = nmode;
    @(posedge clk);
    #1;
    check_val("rsp_valid", {63'd0, rsp_valid}, {63'd0, m_rv});
    check_val("rsp_instr", {32'd0, rsp_instr}, {32'd0, m_instr});
    check_val("err_align", {63'd0, rsp_err_align}, {63'd0, m_ea});
    check_val("err_range", {63'd0, rsp_err_range}, {63'd0, m_er});
    check_val("load_err", {63'd0, load_err}, {63'd0, m_lerr});
    check_val("load_cnt", {32'd0, load_cnt}, {32'd0, m_cnt});
    check_val("busy", {63'd0, busy}, {63'd0, (m_mode != 0)});
  endtask

  // In RUN with load_en high, fetches are blocked, so the held response is
  // gone at the edge exactly when it was empty or taken this cycle.
  function automatic bit m_rv_before(input bit take, input bit acc);
    return m_rv && !take && !acc;
  endfunction

  task automatic write_byte(input logic [31:0] a, input logic [7:0] d);
    load_we = 1'b1; load_addr = a; load_data = d;
    cycle();
    load_we = 1'b0;
  endtask

  logic [7:0] init_bytes [8];

  initial begin
    init_bytes[0] = 8'h00; init_bytes[1] = 8'hFF; init_bytes[2] = 8'h55; init_bytes[3] = 8'h0F;
    init_bytes[4] = 8'hCC; init_bytes[5] = 8'h33; init_bytes[6] = 8'hF0; init_bytes[7] = 8'h92;
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    model_reset();

    // Reset values.
    #12;
    check_val("rst_valid", {63'd0, rsp_valid}, 64'd0);
    check_val("rst_instr", {32'd0, rsp_instr}, 64'd0);
    check_val("rst_errs", {62'd0, rsp_err_align, rsp_err_range}, 64'd0);
    check_val("rst_load", {31'd0, load_err, load_cnt}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_fready", {63'd0, fetch_ready}, 64'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Load the 8-byte image, then fetch 0 and 4 back-to-back.
    load_en = 1'b1; cycle();
    check_val("busy_load", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 8; i++) write_byte(32'(i), init_bytes[i]);
    load_en = 1'b0; cycle();
    check_val("load_cnt8", {32'd0, load_cnt}, 64'd8);
    rsp_ready = 1'b1; fetch_valid = 1'b1; fetch_addr = 32'd0; cycle();
    check_val("fetch0", {32'd0, rsp_instr}, 64'h00FF550F);
    fetch_addr = 32'd4; cycle();
    check_val("fetch4", {32'd0, rsp_instr}, 64'hCC33F092);

    // Hold the response for 3 cycles.
    fetch_valid = 1'b0; rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check_val("hold_instr", {32'd0, rsp_instr}, 64'hCC33F092);
      check_val("hold_fready", {63'd0, fetch_ready}, 64'd0);
    end
    rsp_ready = 1'b1; fetch_valid = 1'b1; fetch_addr = 32'd2; #1;
    check_val("reopen_fready", {63'd0, fetch_ready}, 64'd1);
    cycle();
    check_val("fetch2", {32'd0, rsp_instr}, 64'h550FCC33);
    check_val("fetch2_align", {62'd0, rsp_err_align, rsp_err_range}, 64'd2);
    fetch_valid = 1'b0; cycle();

    // Wrap bytes, a dropped write, and fill the rest of memory.
    load_en = 1'b1; cycle();
    write_byte(32'd254, 8'hAA); write_byte(32'd255, 8'hBB);
    write_byte(32'd0, 8'h11);   write_byte(32'd1, 8'h22);
    write_byte(32'h100, 8'h5A);
    check_val("drop_pulse", {63'd0, load_err}, 64'd1);
    check_val("drop_cnt", {32'd0, load_cnt}, 64'd4);
    cycle();
    check_val("drop_end", {63'd0, load_err}, 64'd0);
    for (int i = 8; i < 254; i++) write_byte(32'(i), 8'($urandom));
    load_en = 1'b0; cycle();
    fetch_valid = 1'b1; fetch_addr = 32'd254; cycle();
    check_val("wrap", {32'd0, rsp_instr}, 64'hAABB1122);
    check_val("wrap_align", {63'd0, rsp_err_align}, 64'd1);
    fetch_addr = 32'h100; cycle();
    check_val("range", {31'd0, rsp_err_range, rsp_instr}, 64'h1_0000_0000);

    // Raise load_en while a response is held.
    fetch_addr = 32'd8; cycle();
    fetch_valid = 1'b0; rsp_ready = 1'b0; load_en = 1'b1;
    load_we = 1'b1; load_addr = 32'd9; load_data = 8'h77;
    cycle(); cycle();
    check_val("drain_busy", {62'd0, busy, rsp_valid}, 64'd3);
    load_we = 1'b0; rsp_ready = 1'b1; cycle();
    check_val("drain_to_load", {62'd0, busy, rsp_valid}, 64'd2);
    rsp_ready = 1'b0;
    write_byte(32'd9, 8'h3C);

    // Reset in the middle of LOAD.
    @(negedge clk); rst_n = 1'b0; #1;
    check_val("mid_rst", {62'd0, rsp_valid, busy}, 64'd0);
    model_reset();
    load_en = 1'b0; #3; rst_n = 1'b1;
    @(posedge clk); #1;
    fetch_valid = 1'b1; fetch_addr = 32'd8; rsp_ready = 1'b1; cycle();
    check_val("retained", {56'd0, rsp_instr[23:16]}, 64'h3C);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      fetch_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 19))
        0:       fetch_addr = $urandom;
        1, 2:    fetch_addr = 32'($urandom_range(256, 511));
        default: fetch_addr = 32'($urandom_range(0, 255));
      endcase
      rsp_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) load_en = ~load_en;
      load_we   = $urandom_range(0, 1);
      load_addr = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(256, 400))
                                              : 32'($urandom_range(0, 255));
      load_data = 8'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
